tone_seq_ctrl: RTL and testbench

- Record/playback controller that sits between the keypad scanner's locked key output and the tone decoder's key input.
- In idle it passes live key presses through as timed notes. In record mode it also stores each press into a DEPTH-entry note buffer. In playback it drives the stored notes to the tone decoder one after another, with a fixed note length and a fixed silent gap between notes.

---
 rtl/tone_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_tone_seq_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tone_seq_ctrl.sv
// tone_seq_ctrl: record/playback sequencer between the
// keypad scanner and the tone decoder.
module tone_seq_ctrl #(
  parameter int DEPTH       = 16,
  parameter int NOTE_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [3:0]                 key_code,
  input  logic                       key_valid,
  input  logic                       rec_btn,
  input  logic                       play_btn,
  input  logic                       clr_btn,
  output logic [3:0]                 tone_code,
  output logic                       tone_on,
  output logic [1:0]                 state,
  output logic [$clog2(DEPTH+1)-1:0] note_cnt,
  output logic [$clog2(DEPTH)-1:0]   play_idx,
  output logic                       full
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int IW   = $clog2(DEPTH);
  localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ?
                        NOTE_CYCLES : GAP_CYCLES;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [TW-1:0] NOTE_LD = TW'(NOTE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_NOTE = 2'b10,
    S_GAP  = 2'b11
  } st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] nxt_idx;
  logic [3:0]    code_q, code_d;
  logic          on_q, on_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          rec_q, play_q, clr_q;
  logic          rec_e, play_e, clr_e;
  logic          tmr_z, last, playing;
  logic          wr_en, live;
  logic [3:0]    mem_q [DEPTH];

  assign rec_e   = rec_btn & ~rec_q;
  assign play_e  = play_btn & ~play_q;
  assign clr_e   = clr_btn & ~clr_q;
  assign tmr_z   = (tmr_q == '0);
  assign playing = st_q[1];
  assign nxt_idx = idx_q + IW'(1);
  assign last    = (CW'(idx_q) + CW'(1)) == cnt_q;

  assign state     = st_q;
  assign note_cnt  = cnt_q;
  assign play_idx  = idx_q;
  assign tone_code = code_q;
  assign tone_on   = on_q;
  assign full      = (cnt_q == CW'(DEPTH));

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    code_d = code_q;
    on_d   = on_q;
    tmr_d  = tmr_q;
    wr_en  = 1'b0;
    live   = 1'b0;
    if (clr_e) begin
      st_d  = S_IDLE;
      cnt_d = '0;
      idx_d = '0;
      on_d  = 1'b0;
      tmr_d = '0;
    end else if (play_e && playing) begin
      st_d  = S_IDLE;
      idx_d = '0;
      on_d  = 1'b0;
      tmr_d = '0;
    end else if (play_e) begin
      if (cnt_q != '0) begin
        st_d   = S_NOTE;
        idx_d  = '0;
        code_d = mem_q[0];
        on_d   = 1'b1;
        tmr_d  = NOTE_LD;
      end else begin
        live = 1'b1;
      end
    end else begin
      unique case (st_q)
        S_IDLE: begin
          live = 1'b1;
          if (rec_e) begin
            st_d  = S_REC;
            cnt_d = '0;
          end
        end
        S_REC: begin
          live = 1'b1;
          if (rec_e) begin
            st_d = S_IDLE;
          end else if (key_valid && !full) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_NOTE: begin
          if (tmr_z) begin
            on_d  = 1'b0;
            tmr_d = GAP_LD;
            st_d  = S_GAP;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        S_GAP: begin
          if (!tmr_z) begin
            tmr_d = tmr_q - TW'(1);
          end else if (last) begin
            st_d  = S_IDLE;
            idx_d = '0;
          end else begin
            idx_d  = nxt_idx;
            code_d = mem_q[nxt_idx];
            on_d   = 1'b1;
            tmr_d  = NOTE_LD;
            st_d   = S_NOTE;
          end
        end
        default: ;
      endcase
    end
    // live notes: a fresh key restarts, otherwise count down
    if (live) begin
      if (key_valid && !play_e) begin
        code_d = key_code;
        on_d   = 1'b1;
        tmr_d  = NOTE_LD;
      end else if (on_q) begin
        if (tmr_z) on_d = 1'b0;
        else       tmr_d = tmr_q - TW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      idx_q  <= '0;
      code_q <= '0;
      on_q   <= 1'b0;
      tmr_q  <= '0;
      rec_q  <= 1'b0;
      play_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      code_q <= code_d;
      on_q   <= on_d;
      tmr_q  <= tmr_d;
      rec_q  <= rec_btn;
      play_q <= play_btn;
      clr_q  <= clr_btn;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) mem_q[cnt_q[IW-1:0]] <= key_code;
  end

endmodule

// File: tb/tb_tone_seq_ctrl.sv
// tb_tone_seq_ctrl: randomized record/playback checks
// against a queue-based note model.
module tb_tone_seq_ctrl;

  localparam int DEPTH = 4;
  localparam int NOTE  = 4;
  localparam int GAP   = 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       rec_btn;
  logic       play_btn;
  logic       clr_btn;
  logic [3:0] tone_code;
  logic       tone_on;
  logic [1:0] state;
  logic [2:0] note_cnt;
  logic [1:0] play_idx;
  logic       full;

  int checks;
  int errors;
  logic [3:0] model_q[$];

  tone_seq_ctrl #(
    .DEPTH(DEPTH),
    .NOTE_CYCLES(NOTE),
    .GAP_CYCLES(GAP)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .key_code(key_code),
    .key_valid(key_valid),
    .rec_btn(rec_btn),
    .play_btn(play_btn),
    .clr_btn(clr_btn),
    .tone_code(tone_code),
    .tone_on(tone_on),
    .state(state),
    .note_cnt(note_cnt),
    .play_idx(play_idx),
    .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input bit r, input bit p, input bit c);
    rec_btn  = r;
    play_btn = p;
    clr_btn  = c;
    @(negedge clk);
    rec_btn  = 1'b0;
    play_btn = 1'b0;
    clr_btn  = 1'b0;
  endtask

  task automatic key(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({tone_on, state, note_cnt, full} !== 7'd0) begin
      errors++;
      $display("FAIL rst_init on/st/cnt/full=%b exp 0",
               {tone_on, state, note_cnt, full});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    key(4'h9);
    checks++;
    if (tone_on !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre tone_on=%b exp 1", tone_on);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tone_on !== 1'b0 || state !== 2'b00 ||
        note_cnt !== 3'd0 || tone_code !== 4'd0) begin
      errors++;
      $display("FAIL rst_async on=%b st=%b cnt=%0d code=%0d exp 0",
               tone_on, state, note_cnt, tone_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_live();
    logic [3:0] c;
    bit         exp_on;
    for (int r = 0; r < 3; r++) begin
      c = (r == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      key(c);
      for (int i = 0; i < NOTE + 2; i++) begin
        exp_on = (i < NOTE);
        checks++;
        if (tone_on !== exp_on || note_cnt !== 3'd0 ||
            state !== 2'b00 || (exp_on && tone_code !== c)) begin
          errors++;
          $display("FAIL live[%0d] on=%b code=%0d cnt=%0d exp on=%b code=%0d",
                   i, tone_on, tone_code, note_cnt, exp_on, c);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_record_play(input int n, input bit fixed);
    logic [3:0] c;
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b01 || note_cnt !== 3'd0) begin
      errors++;
      $display("FAIL rec_enter st=%b cnt=%0d exp 01/0",
               state, note_cnt);
    end
    model_q.delete();
    for (int k = 0; k < n; k++) begin
      c = fixed ? 4'(k + 1) : 4'($urandom_range(0, 15));
      key(c);
      if (model_q.size() < DEPTH) model_q.push_back(c);
      checks++;
      if (note_cnt !== model_q.size() ||
          full !== (model_q.size() == DEPTH) ||
          tone_code !== c || tone_on !== 1'b1) begin
        errors++;
        $display("FAIL rec_key[%0d] cnt=%0d full=%b code=%0d on=%b exp %0d/%0d",
                 k, note_cnt, full, tone_code, tone_on,
                 model_q.size(), c);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    press(1'b1, 1'b0, 1'b0);
    checks++;
    if (state !== 2'b00 || note_cnt !== model_q.size()) begin
      errors++;
      $display("FAIL rec_exit st=%b cnt=%0d exp 00/%0d",
               state, note_cnt, model_q.size());
    end
    press(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < model_q.size(); k++) begin
      for (int i = 0; i < NOTE; i++) begin
        checks++;
        if (state !== 2'b10 || tone_on !== 1'b1 ||
            tone_code !== model_q[k] || play_idx !== 2'(k)) begin
          errors++;
          $display("FAIL play_note[%0d.%0d] st=%b on=%b code=%0d idx=%0d exp code=%0d",
                   k, i, state, tone_on, tone_code, play_idx,
                   model_q[k]);
        end
        @(negedge clk);
      end
      for (int i = 0; i < GAP; i++) begin
        checks++;
        if (state !== 2'b11 || tone_on !== 1'b0) begin
          errors++;
          $display("FAIL play_gap[%0d.%0d] st=%b on=%b exp 11/0",
                   k, i, state, tone_on);
        end
        @(negedge clk);
      end
    end
    checks++;
    if (state !== 2'b00 || tone_on !== 1'b0 ||
        play_idx !== 2'd0 || note_cnt !== model_q.size()) begin
      errors++;
      $display("FAIL play_end st=%b on=%b idx=%0d cnt=%0d exp 00/0/0/%0d",
               state, tone_on, play_idx, note_cnt, model_q.size());
    end
  endtask

  task automatic test_abort();
    press(1'b0, 1'b1, 1'b0);
    repeat (NOTE + GAP) @(negedge clk);
    key(~model_q[1]);
    checks++;
    if (state !== 2'b10 || tone_on !== 1'b1 ||
        tone_code !== model_q[1] || play_idx !== 2'd1) begin
      errors++;
      $display("FAIL abort_key st=%b on=%b code=%0d idx=%0d exp code=%0d",
               state, tone_on, tone_code, play_idx, model_q[1]);
    end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b00 || tone_on !== 1'b0 ||
        play_idx !== 2'd0 || note_cnt !== 3'd3) begin
      errors++;
      $display("FAIL abort st=%b on=%b idx=%0d cnt=%0d exp 00/0/0/3",
               state, tone_on, play_idx, note_cnt);
    end
  endtask

  task automatic test_clr_play();
    checks++;
    if (note_cnt !== 3'd3) begin
      errors++;
      $display("FAIL clr_pre cnt=%0d exp 3", note_cnt);
    end
    press(1'b0, 1'b1, 1'b1);
    checks++;
    if (note_cnt !== 3'd0 || state !== 2'b00 ||
        full !== 1'b0 || tone_on !== 1'b0) begin
      errors++;
      $display("FAIL clr_play cnt=%0d st=%b full=%b on=%b exp 0/00/0/0",
               note_cnt, state, full, tone_on);
    end
    press(1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'b00 || tone_on !== 1'b0) begin
      errors++;
      $display("FAIL play_empty st=%b on=%b exp 00/0", state, tone_on);
    end
    press(1'b1, 1'b0, 1'b0);
    key(4'hA);
    press(1'b0, 1'b0, 1'b1);
    checks++;
    if (state !== 2'b00 || note_cnt !== 3'd0 || tone_on !== 1'b0) begin
      errors++;
      $display("FAIL clr_rec st=%b cnt=%0d on=%b exp 00/0/0",
               state, note_cnt, tone_on);
    end
  endtask

  task automatic test_reset_mid_play();
    press(1'b1, 1'b0, 1'b0);
    key(4'($urandom_range(1, 15)));
    key(4'($urandom_range(1, 15)));
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (state !== 2'b10 || tone_on !== 1'b1) begin
      errors++;
      $display("FAIL rmp_pre st=%b on=%b exp 10/1", state, tone_on);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({tone_on, state, note_cnt, play_idx, full, tone_code}
        !== 13'd0) begin
      errors++;
      $display("FAIL rst_mid_play on=%b st=%b cnt=%0d idx=%0d full=%b code=%0d exp 0",
               tone_on, state, note_cnt, play_idx, full, tone_code);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    key_code  = 4'd0;
    key_valid = 1'b0;
    rec_btn   = 1'b0;
    play_btn  = 1'b0;
    clr_btn   = 1'b0;
    test_reset();
    test_live();
    test_record_play(3, 1'b1);
    test_abort();
    test_clr_play();
    test_record_play(5, 1'b1);
    for (int r = 0; r < 4; r++)
      test_record_play($urandom_range(1, 6), 1'b0);
    test_reset_mid_play();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
